agu_station: RTL
================

Name: agu_station

Overview:
- Address-generation reservation station that sits directly upstream of the load/store queue.
- Accepts memory ops at dispatch and holds each one until its base register is available.
- Computes the effective address, then broadcasts it on the CDB with ready=0. The LSQ snoops that broadcast as the address for the matching rob_id.
- One address is produced per cycle, oldest ready entry first.

Parameters:
- NUM_ENTRIES, 4, number of station entries (power of two, 2..8).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- flush  input  1  pipeline flush; discards all entries and the output stage.
- new_entry  input  1  dispatch request.
- new_op  input  lc3b_lsq_op  memory op kind.
- new_rob_id  input  lc3b_rob_id  ROB tag of the op; also used as the broadcast dest.
- new_base  input  lc3b_regfile_entry  base register: value, plus rob_id (REORDER_ID_INVALID means the value is valid).
- new_imm  input  8  raw immediate: offset6 in [5:0], trapvect8 in [7:0].
- data_bus  input  lc3b_cdb  CDB snoop.
- rob_data  input  lc3b_rob_entry[REORDER_BUFFER_SIZE]  ROB contents, for late operand pickup.
- full  output  1  no free entry.
- out_valid  output  1  output stage holds an address awaiting the bus.
- out_bus  output  lc3b_cdb  broadcast payload.
- out_grant  input  1  CDB arbiter accepted out_bus this cycle.

Behaviour:
- Reset/flush:
  - All entries invalid; out_valid=0; out_bus all zero.
  - full=0 in the following cycle.
  - flush overrides every same-cycle allocate, capture, issue and grant.
  - Reset mid-operation behaves identically.
- Storage and ordering:
  - Shift-compacting queue; index 0 is the oldest.
  - An entry holds: valid, op, rob_id, base_ready, base_value, base_rob_id, imm.
  - full = all NUM_ENTRIES valid.
- Allocation (new_entry && !full):
  - Write at the lowest invalid index after compaction.
  - base_ready=1 in either case below:
    - new_base.rob_id == REORDER_ID_INVALID;
    - data_bus.ready && data_bus.dest == new_base.rob_id, in which case the data_bus value is taken.
  - For op lq_trap the base is ignored and base_ready=1.
  - new_entry while full is dropped silently; the upstream stage must respect full.
- Operand capture, per valid entry with !base_ready:
  - If data_bus.ready && data_bus.dest == base_rob_id, take data_bus.value.
  - Otherwise, if rob_data[base_rob_id].valid && .ready, take its value.
  - data_bus.ready=0 broadcasts (addresses) are never captured as operands.
- Address arithmetic (16-bit, wrap modulo 2^16):
  - lq_ldr, lq_ldi, sq_str, sq_sti: base + (sext(imm[5:0]) << 1).
  - lq_ldb, sq_stb: base + sext(imm[5:0]).
  - lq_trap: zext(imm[7:0]); the LSQ applies the <<1 itself.
- Issue:
  - Condition: the output stage is empty, or out_grant=1 this cycle.
  - The lowest-index entry with base_ready is selected.
  - Its address is registered into out_bus: dest=rob_id, value=address, ready=0, update_pc=0, update_pc_value=0.
  - out_valid=1; the entry is freed and the queue compacts in the same edge.
  - An entry is not eligible in the same cycle its operand is captured.
  - Minimum latency: an allocation with ready base gives out_valid at edge+1, since allocation and issue occur on separate edges.
- Output handshake:
  - out_bus is held stable while out_valid && !out_grant.
  - out_grant with out_valid=0 is ignored.
  - Sustained throughput is one address per cycle while grants keep arriving.
- Simultaneous events:
  - Allocate, capture, issue and grant may all occur in one cycle.
  - full reflects post-edge occupancy.
  - Freeing and allocating in one cycle is legal even when previously full only if full was 0 at the sample point. full is not bypassed.

Decomposition:
- lc3b_types gains the lc3b_agu_entry struct and a `AGU_ENTRIES default macro.
- A sub-module agu_calc (combinational: op, base, imm -> address) implements the arithmetic and is reused by the issue path.
- The station is otherwise one module.

Test Plan:
- Reset, then dispatch ldr, base {INVALID, x3000}, imm 6'h3F -> after 1 cycle out_valid=1, out_bus.value=x2FFE, ready=0, dest=tag; grant -> out_valid=0.
- Dispatch stb, base waiting on ROB 5; next cycle CDB {dest 5, ready 1, value x4001}, imm 6'h01 -> address x4002 issued the cycle after capture.
- Dispatch trap with imm x25 -> value x0025; base ignored even when base.rob_id is pending.
- Fill 4 entries with pending bases -> full=1; a 5th new_entry is dropped. Wake entry 2 via rob_data -> it issues ahead of older entries 0-1; full deasserts.
- Hold out_grant=0 for 3 cycles with 2 ready entries -> out_bus stable; grant every cycle afterwards -> second address issues on the next cycle.
- Flush with 3 entries and out_valid=1, new_entry asserted the same cycle -> all cleared, out_valid=0, full=0. Same outcome with reset.

Source files
------------

// File: rtl/agu_station_pkg.sv
// Shared LC-3b types for the address-generation station: ROB tags, CDB payload, ROB entries, station entries.
// Types and constants only; no timing of its own.
// No flow control here; the users of these types define it.
`ifndef AGU_ENTRIES
`define AGU_ENTRIES 4
`endif

package agu_station_pkg;

   localparam int REORDER_BUFFER_SIZE = 8;
   localparam int ROB_IDX_W           = 3;

   typedef logic [15:0] lc3b_word;

   // One extra tag bit so the "no producer" tag never aliases a real ROB slot.
   typedef logic [3:0] lc3b_rob_id;
   localparam lc3b_rob_id REORDER_ID_INVALID = 4'h8;

   typedef enum logic [2:0] {
      lq_ldr, lq_ldb, lq_ldi, lq_trap, sq_str, sq_stb, sq_sti
   } lc3b_lsq_op;

   typedef struct packed {
      lc3b_rob_id rob_id;
      lc3b_word   value;
   } lc3b_regfile_entry;

   typedef struct packed {
      logic       ready;
      lc3b_rob_id dest;
      lc3b_word   value;
      logic       update_pc;
      lc3b_word   update_pc_value;
   } lc3b_cdb;

   typedef struct packed {
      logic     valid;
      logic     ready;
      lc3b_word value;
   } lc3b_rob_entry;

   typedef struct packed {
      logic       valid;
      lc3b_lsq_op op;
      lc3b_rob_id rob_id;
      logic       base_ready;
      lc3b_word   base_value;
      lc3b_rob_id base_rob_id;
      logic [7:0] imm;
   } lc3b_agu_entry;

endpackage

// File: rtl/agu_station_calc.sv
// Effective-address arithmetic for one memory op (base + scaled offset6, or zero-extended trap vector).
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is consumed.
module agu_calc
   import agu_station_pkg::*;
(
   input  lc3b_lsq_op i_op,
   input  lc3b_word   i_base,
   input  logic [7:0] i_imm,
   output lc3b_word   o_addr
);

   lc3b_word w_off6;
   assign w_off6 = {{10{i_imm[5]}}, i_imm[5:0]};

   // word ops scale the offset, byte ops do not, trap passes the raw vector (LSQ shifts it)
   always_comb begin
      o_addr = i_base + w_off6;
      case (i_op)
         lq_ldr, lq_ldi, sq_str, sq_sti: o_addr = i_base + (w_off6 << 1);
         lq_trap:                        o_addr = {8'h00, i_imm};
         default:                        o_addr = i_base + w_off6;
      endcase
   end

endmodule

// File: rtl/agu_station.sv
// Reservation station in front of the LSQ: holds memory ops until their base is known, then broadcasts the address on the CDB with ready=0.
// Allocation and issue are on separate edges, so a ready op shows out_valid one edge after it is written.
// Output stage holds out_bus until out_grant; full stops dispatch and is not bypassed by a same-cycle issue.
module agu_station
   import agu_station_pkg::*;
#(
   parameter int NUM_ENTRIES = `AGU_ENTRIES
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              new_entry,
   input  lc3b_lsq_op        new_op,
   input  lc3b_rob_id        new_rob_id,
   input  lc3b_regfile_entry new_base,
   input  logic [7:0]        new_imm,
   input  lc3b_cdb           data_bus,
   input  lc3b_rob_entry     rob_data [REORDER_BUFFER_SIZE],
   output logic              full,
   output logic              out_valid,
   output lc3b_cdb           out_bus,
   input  logic              out_grant
);

   localparam int IW = $clog2(NUM_ENTRIES);
   localparam int CW = IW + 1;

   lc3b_agu_entry r_q     [NUM_ENTRIES];
   lc3b_agu_entry w_cap   [NUM_ENTRIES];
   lc3b_agu_entry w_q_nxt [NUM_ENTRIES];
   lc3b_agu_entry w_new;
   logic          r_out_valid;
   lc3b_cdb       r_out_bus;
   lc3b_cdb       w_out_bus;
   logic          w_found;
   logic          w_issue;
   logic          w_full;
   logic [IW-1:0] w_sel;
   logic [CW-1:0] w_cnt;
   logic [CW-1:0] w_slot;
   lc3b_word      w_addr;
   logic          w_unused;

   // PC-redirect fields of the snooped bus are irrelevant to address generation
   assign w_unused = ^{data_bus.update_pc, data_bus.update_pc_value};

   // occupancy count and oldest (lowest-index) entry whose base was ready before this edge
   always_comb begin
      w_full  = 1'b1;
      w_cnt   = '0;
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         w_full = w_full & r_q[i].valid;
         w_cnt  = w_cnt + CW'(r_q[i].valid);
         if (r_q[i].valid && r_q[i].base_ready) begin
            w_found = 1'b1;
            w_sel   = IW'(i);
         end
      end
   end

   assign w_issue = w_found && (!r_out_valid || out_grant);
   assign w_slot  = w_cnt - CW'(w_issue);

   agu_calc u_calc (
      .i_op   (r_q[w_sel].op),
      .i_base (r_q[w_sel].base_value),
      .i_imm  (r_q[w_sel].imm),
      .o_addr (w_addr)
   );

   // address broadcast payload: ready=0 marks it as an address, not a result
   always_comb begin
      w_out_bus       = '0;
      w_out_bus.dest  = r_q[w_sel].rob_id;
      w_out_bus.value = w_addr;
   end

   // late operand pickup for waiting entries: CDB result first, then ROB contents
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         w_cap[i] = r_q[i];
         if (r_q[i].valid && !r_q[i].base_ready) begin
            if (data_bus.ready && data_bus.dest == r_q[i].base_rob_id) begin
               w_cap[i].base_ready = 1'b1;
               w_cap[i].base_value = data_bus.value;
            end else if (rob_data[r_q[i].base_rob_id[ROB_IDX_W-1:0]].valid &&
                         rob_data[r_q[i].base_rob_id[ROB_IDX_W-1:0]].ready) begin
               w_cap[i].base_ready = 1'b1;
               w_cap[i].base_value = rob_data[r_q[i].base_rob_id[ROB_IDX_W-1:0]].value;
            end
         end
      end
   end

   // dispatched entry; trap ignores its base, otherwise the base may already be known or on the CDB now
   always_comb begin
      w_new             = '0;
      w_new.valid       = 1'b1;
      w_new.op          = new_op;
      w_new.rob_id      = new_rob_id;
      w_new.imm         = new_imm;
      w_new.base_rob_id = new_base.rob_id;
      w_new.base_value  = new_base.value;
      if (new_op == lq_trap || new_base.rob_id == REORDER_ID_INVALID) begin
         w_new.base_ready = 1'b1;
      end else if (data_bus.ready && data_bus.dest == new_base.rob_id) begin
         w_new.base_ready = 1'b1;
         w_new.base_value = data_bus.value;
      end
   end

   // compact over the issued slot, then append the dispatched op at the first free index
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) w_q_nxt[i] = w_cap[i];
      if (w_issue) begin
         for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
            if (i >= int'(w_sel)) w_q_nxt[i] = w_cap[i + 1];
         end
         w_q_nxt[NUM_ENTRIES - 1] = '0;
      end
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (new_entry && !w_full && i == int'(w_slot)) w_q_nxt[i] = w_new;
      end
   end

   // queue and output stage; reset and flush override every same-cycle update
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) r_q[i] <= '0;
         r_out_valid <= 1'b0;
         r_out_bus   <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) r_q[i] <= w_q_nxt[i];
         if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_bus   <= w_out_bus;
         end else if (out_grant) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign full      = w_full;
   assign out_valid = r_out_valid;
   assign out_bus   = r_out_bus;

endmodule
